io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the single peripheral I/O bus (LED, 7-seg and UART registers at 0x2000 and up) between two masters.
- Master 0 is the j1 CPU I/O port; master 1 is the debug/loader master.
- Round-robin grant; one transaction at a time.
- Slave wait states via s_ready; a timeout counter stops a missing slave from hanging a master.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 15, max cycles in ACCESS without s_ready before error completion; range 1..255.

Ports:
- sys_clk_i  in  1  clock.
- sys_rst_n_i  in  1  reset, asynchronous, active-low.
- m_req  in  2  per-master request; level, held until ack.
- m_wr  in  2  per-master direction: 1 = write, 0 = read.
- m_addr  in  2xAW  per-master address.
- m_wdata  in  2xDW  per-master write data.
- m_ack  out  2  one-cycle completion pulse to the granted master.
- m_err  out  2  one-cycle timeout flag; coincident with m_ack.
- m_rdata  out  DW  read data; shared; valid only while m_ack is high.
- s_rd  out  1  slave read strobe.
- s_wr  out  1  slave write strobe.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_rdata  in  DW  slave read data; sampled when s_ready = 1.
- s_ready  in  1  slave completion.

Behaviour:
- All outputs are registered.
- Reset values: m_ack = 0, m_err = 0, m_rdata = 0, s_rd = 0, s_wr = 0, s_addr = 0, s_wdata = 0, state = IDLE, prio = 0, timeout count = 0, grant = 0.
- Async reset mid-transaction drops s_rd/s_wr immediately; the transaction is discarded with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select the granted master g: if both request, g = prio; else g = the single requester.
  - Latch m_addr[g]/m_wdata[g] into s_addr/s_wdata.
  - Set s_rd = ~m_wr[g] and s_wr = m_wr[g]; clear the count; go to ACCESS.
  - Set prio <= ~g.
- ACCESS:
  - s_rd/s_wr and s_addr/s_wdata stay stable.
  - If s_ready: capture s_rdata (reads only; writes give m_rdata = 0), drop the strobes, go to DONE with err = 0.
  - Else if count == TIMEOUT-1: drop the strobes, set m_rdata = 0, go to DONE with err = 1.
  - Else count += 1.
- DONE:
  - m_ack[g] = 1 and m_err[g] = err for exactly one cycle, then return to IDLE.
  - No new grant is made in DONE, so there is one idle bus cycle between transactions.
- Master rule: a master deasserts m_req at the same clock edge that samples m_ack = 1. Its next request is seen in IDLE no earlier than the cycle after DONE.
- Requests that arrive or change while another master is granted are ignored until IDLE.
- Latency, zero-wait slave:
  - Edge 0: IDLE samples the request.
  - Cycle 1: ACCESS, strobe high; s_ready is sampled at the end of cycle 1.
  - Cycle 2: DONE, ack high.
  - Total: 2 cycles from request sample to ack; each slave wait cycle adds 1.
- Timeout: with TIMEOUT = N and s_ready never asserted, the strobe is high for exactly N cycles, then ack+err.
- s_ready outside ACCESS is ignored.
- m_req asserted together with reset release: not sampled until the first edge after release.

Decomposition:
- Package io_bus_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} io_state_t.
  - localparams IO_LEDG_ADDR = 16'h2000, IO_LEDR_ADDR = 16'h2001.
  - Default AW/DW.
  - Bus record struct {addr, wdata, wr}.
- Sub-module rr_arbiter2: 2-bit request in, one-hot grant plus index out, registered prio pointer updated on an accept input. The main FSM instantiates it once.

Test Plan:
- Single write: m0 writes 0x2000 with data 0x00A5, s_ready tied 1 -> s_wr high 1 cycle with s_addr = 0x2000, s_wdata = 0x00A5; m_ack[0] 2 cycles after request sample; m_err = 0.
- Read with waits: m1 reads 0x2001, s_ready after 3 wait cycles, s_rdata = 0x0155 -> s_rd high 4 cycles; m_ack[1] with m_rdata = 0x0155 on the next cycle.
- Contention: both request from reset -> m0 served first, then m1; repeat with both held -> the grant order alternates 0,1,0,1, with one idle cycle between transactions.
- Timeout: TIMEOUT = 15, s_ready held 0 -> s_rd high exactly 15 cycles; m_ack[0] = m_err[0] = 1 with m_rdata = 0; the arbiter returns to IDLE and serves the next request normally.
- Reset mid-access: assert sys_rst_n_i low during an ACCESS wait -> s_rd/s_wr go 0 asynchronously with no ack; after release, prio = 0 and a new m1 request completes normally.
- Late request: m1 raises its request while m0 is in ACCESS -> m1 is not granted until the IDLE following m0's DONE; s_addr stays at m0's address throughout.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the peripheral I/O bus arbiter.
package io_bus_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  localparam logic [DEF_AW-1:0] IO_LEDG_ADDR = 16'h2000;
  localparam logic [DEF_AW-1:0] IO_LEDR_ADDR = 16'h2001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } io_state_t;

  // One master's transaction request at default bus widths
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
    logic              wr;
  } io_bus_rec_t;

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; priority pointer advances only on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_c,
  output logic       idx_c
);

  logic prio_q;

  always_comb begin
    idx_c   = 1'b0;
    grant_c = 2'b00;
    unique case (req)
      2'b11:   idx_c = prio_q;
      2'b10:   idx_c = 1'b1;
      default: idx_c = 1'b0;
    endcase
    if (req != 2'b00) begin
      grant_c = {idx_c, ~idx_c};
    end
  end

  // The master just served loses priority to the other one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= ~idx_c;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the peripheral I/O bus between the CPU (master 0) and the debug
// loader (master 1); one transaction at a time with a slave timeout.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_n_i,
  input  logic [1:0]           m_req,
  input  logic [1:0]           m_wr,
  input  logic [1:0][AW-1:0]   m_addr,
  input  logic [1:0][DW-1:0]   m_wdata,
  output logic [1:0]           m_ack,
  output logic [1:0]           m_err,
  output logic [DW-1:0]        m_rdata,
  output logic                 s_rd,
  output logic                 s_wr,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  input  logic [DW-1:0]        s_rdata,
  input  logic                 s_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } bus_rec_t;

  io_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gidx_q, gidx_d;

  logic [1:0]       m_ack_d, m_err_d;
  logic [DW-1:0]    m_rdata_d;
  logic             s_rd_d, s_wr_d;
  logic [AW-1:0]    s_addr_d;
  logic [DW-1:0]    s_wdata_d;

  logic             arb_accept_c;
  logic [1:0]       arb_grant_c;
  logic             arb_idx_c;
  bus_rec_t         sel_c;
  logic             timed_out_c;

  assign arb_accept_c = (state_q == IDLE) && (m_req != 2'b00);
  assign timed_out_c  = (cnt_q == TO_LAST);

  rr_arbiter2 u_arb (
    .clk     (sys_clk_i),
    .rst_n   (sys_rst_n_i),
    .req     (m_req),
    .accept  (arb_accept_c),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c)
  );

  // AND-OR mux of the granted master's request fields
  always_comb begin
    sel_c.addr  = ({AW{arb_grant_c[0]}} & m_addr[0])  | ({AW{arb_grant_c[1]}} & m_addr[1]);
    sel_c.wdata = ({DW{arb_grant_c[0]}} & m_wdata[0]) | ({DW{arb_grant_c[1]}} & m_wdata[1]);
    sel_c.wr    = |(arb_grant_c & m_wr);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (m_req != 2'b00) state_d = ACCESS;
      ACCESS:  if (s_ready || timed_out_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; hold by default
  always_comb begin
    m_ack_d   = 2'b00;
    m_err_d   = 2'b00;
    m_rdata_d = m_rdata;
    s_rd_d    = s_rd;
    s_wr_d    = s_wr;
    s_addr_d  = s_addr;
    s_wdata_d = s_wdata;
    cnt_d     = cnt_q;
    gidx_d    = gidx_q;
    unique case (state_q)
      IDLE: begin
        if (m_req != 2'b00) begin
          s_addr_d  = sel_c.addr;
          s_wdata_d = sel_c.wdata;
          s_wr_d    = sel_c.wr;
          s_rd_d    = ~sel_c.wr;
          cnt_d     = '0;
          gidx_d    = arb_idx_c;
        end
      end
      ACCESS: begin
        if (s_ready) begin
          s_rd_d    = 1'b0;
          s_wr_d    = 1'b0;
          m_rdata_d = s_wr ? '0 : s_rdata;
          m_ack_d   = {gidx_q, ~gidx_q};
        end else if (timed_out_c) begin
          s_rd_d    = 1'b0;
          s_wr_d    = 1'b0;
          m_rdata_d = '0;
          m_ack_d   = {gidx_q, ~gidx_q};
          m_err_d   = {gidx_q, ~gidx_q};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      m_ack   <= 2'b00;
      m_err   <= 2'b00;
      m_rdata <= '0;
      s_rd    <= 1'b0;
      s_wr    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      cnt_q   <= '0;
      gidx_q  <= 1'b0;
    end else begin
      m_ack   <= m_ack_d;
      m_err   <= m_err_d;
      m_rdata <= m_rdata_d;
      s_rd    <= s_rd_d;
      s_wr    <= s_wr_d;
      s_addr  <= s_addr_d;
      s_wdata <= s_wdata_d;
      cnt_q   <= cnt_d;
      gidx_q  <= gidx_d;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed, table-driven bench for io_bus_arbiter.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  logic              sys_clk_i = 1'b0;
  logic              sys_rst_n_i;
  logic [1:0]        m_req, m_wr;
  logic [1:0][15:0]  m_addr, m_wdata;
  logic [1:0]        m_ack, m_err;
  logic [15:0]       m_rdata;
  logic              s_rd, s_wr;
  logic [15:0]       s_addr, s_wdata, s_rdata;
  logic              s_ready;

  int n_pass = 0;
  int n_total = 0;

  io_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_n_i (sys_rst_n_i),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .m_rdata     (m_rdata),
    .s_rd        (s_rd),
    .s_wr        (s_wr),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    int          m;
    io_bus_rec_t bus;
    int          waits;     // -1: slave never answers
    logic [15:0] srdata;
    int          lat;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [15:0] rdata;
    int          strobes;
  } vec_t;

  function automatic vec_t mk(input int m, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input int waits,
                              input logic [15:0] srdata, input int lat,
                              input logic [1:0] ack, input logic [1:0] err,
                              input logic [15:0] rdata, input int strobes);
    vec_t v;
    v.m = m; v.bus.addr = addr; v.bus.wdata = wdata; v.bus.wr = wr;
    v.waits = waits; v.srdata = srdata; v.lat = lat; v.ack = ack;
    v.err = err; v.rdata = rdata; v.strobes = strobes;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Drives one single-master transaction from IDLE and checks its completion
  task automatic run_txn(input vec_t v, input string tag);
    int lat, scnt, bad;
    logic got;
    lat = 0; scnt = 0; bad = 0; got = 1'b0;
    m_wr[v.m] = v.bus.wr; m_addr[v.m] = v.bus.addr; m_wdata[v.m] = v.bus.wdata;
    s_rdata = v.srdata; s_ready = 1'b0;
    m_req[v.m] = 1'b1;
    while (!got && lat < 300) begin
      @(negedge sys_clk_i); lat++;
      if (m_ack != 2'b00) begin
        got = 1'b1;
      end else if (s_rd || s_wr) begin
        scnt++;
        if ({s_wr, s_rd} != (v.bus.wr ? 2'b10 : 2'b01) || s_addr != v.bus.addr ||
            (v.bus.wr && s_wdata != v.bus.wdata)) bad++;
        s_ready = (v.waits >= 0) && (scnt > v.waits);
      end else begin
        s_ready = 1'b0;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_ack"}, 32'(m_ack), 32'(v.ack));
    chk({tag, "_err"}, 32'(m_err), 32'(v.err));
    chk({tag, "_rdata"}, 32'(m_rdata), 32'(v.rdata));
    chk({tag, "_strobes"}, 32'(scnt), 32'(v.strobes));
    chk({tag, "_bus"}, 32'(bad), 32'd0);
    s_ready = 1'b0;
    m_req[v.m] = 1'b0;
    @(negedge sys_clk_i);
    chk({tag, "_pulse"}, 32'({m_ack, m_err}), 32'd0);
  endtask

  vec_t vecs[5];
  vec_t post_rst;
  int cyc, scnt, bad;

  initial begin
    sys_rst_n_i = 1'b0;
    m_req = '0; m_wr = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_ready = 1'b0;

    vecs[0] = mk(0, 1'b1, IO_LEDG_ADDR, 16'h00A5, 0,  16'h1111, 2,  2'b01, 2'b00, 16'h0000, 1);
    vecs[1] = mk(1, 1'b0, IO_LEDR_ADDR, 16'h0000, 3,  16'h0155, 5,  2'b10, 2'b00, 16'h0155, 4);
    vecs[2] = mk(0, 1'b0, IO_LEDG_ADDR, 16'h0000, -1, 16'hDEAD, 16, 2'b01, 2'b01, 16'h0000, 15);
    vecs[3] = mk(1, 1'b1, IO_LEDR_ADDR, 16'h1234, 1,  16'hBEEF, 3,  2'b10, 2'b00, 16'h0000, 2);
    vecs[4] = mk(0, 1'b0, 16'h2003,     16'h0000, 0,  16'hABCD, 2,  2'b01, 2'b00, 16'hABCD, 1);
    post_rst = mk(1, 1'b0, IO_LEDR_ADDR, 16'h0000, 0, 16'h0777, 2,  2'b10, 2'b00, 16'h0777, 1);

    #1;
    chk("rst_ctl", 32'({m_ack, m_err, s_rd, s_wr}), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_data", 32'({m_rdata, s_wdata}), 32'd0);
    repeat (2) @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
    @(negedge sys_clk_i);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both masters request out of reset and stay requesting: 0,1,0,1
    sys_rst_n_i = 1'b0;
    m_wr = 2'b00; m_addr[0] = IO_LEDG_ADDR; m_addr[1] = IO_LEDR_ADDR;
    s_ready = 1'b1; s_rdata = 16'h0055;
    m_req = 2'b11;
    @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      while (!(s_rd || s_wr) && cyc < 20) begin
        @(negedge sys_clk_i); cyc++;
      end
      chk($sformatf("rr%0d_strobe", t), 32'(s_rd), 32'd1);
      chk($sformatf("rr%0d_addr", t), 32'(s_addr), (t % 2 == 1) ? 32'h2001 : 32'h2000);
      @(negedge sys_clk_i);
      chk($sformatf("rr%0d_ack", t), 32'(m_ack), (t % 2 == 1) ? 32'd2 : 32'd1);
      m_req[t % 2] = 1'b0;
      @(negedge sys_clk_i);
      chk($sformatf("rr%0d_gap", t), 32'({s_rd, s_wr}), 32'd0);
      m_req[t % 2] = 1'b1;
    end
    m_req = 2'b00; s_ready = 1'b0;
    @(negedge sys_clk_i);

    // m1 raises its request while m0 is mid-access
    m_addr[0] = IO_LEDG_ADDR; m_addr[1] = IO_LEDR_ADDR; m_wr = 2'b00;
    s_rdata = 16'h0042;
    m_req[0] = 1'b1;
    cyc = 0; scnt = 0; bad = 0;
    while (m_ack == 2'b00 && cyc < 20) begin
      if (cyc == 1) m_req[1] = 1'b1;
      if (s_rd || s_wr) begin
        scnt++;
        if (s_addr != 16'h2000) bad++;
      end
      s_ready = (scnt >= 3);
      @(negedge sys_clk_i); cyc++;
    end
    chk("late_ack0", 32'(m_ack), 32'd1);
    chk("late_addr_stable", 32'(bad), 32'd0);
    chk("late_strobes", 32'(scnt), 32'd3);
    s_ready = 1'b0; m_req[0] = 1'b0;
    @(negedge sys_clk_i);
    chk("late_gap", 32'({s_rd, s_wr}), 32'd0);
    @(negedge sys_clk_i);
    chk("late_m1_addr", 32'(s_addr), 32'h2001);
    s_ready = 1'b1;
    @(negedge sys_clk_i);
    chk("late_ack1", 32'(m_ack), 32'd2);
    chk("late_rdata", 32'(m_rdata), 32'h0042);
    m_req = 2'b00; s_ready = 1'b0;
    @(negedge sys_clk_i);

    // Asynchronous reset during a stalled read
    m_req[0] = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    chk("rstmid_pre", 32'(s_rd), 32'd1);
    #1 sys_rst_n_i = 1'b0;
    #1;
    chk("rstmid_strobe", 32'({s_rd, s_wr}), 32'd0);
    chk("rstmid_ack", 32'({m_ack, m_err}), 32'd0);
    m_req = 2'b00;
    @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
    @(negedge sys_clk_i);
    run_txn(post_rst, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
